// File: rtl/dual_port_ram_pipe_if.sv
// Write/read port bundle for dual_port_ram_pipe; master drives requests, slave returns read data.
// Combinational wiring only, no latency; no backpressure, requests are always sampled.
// init_busy tells the master that requests are being dropped during the clear sweep.
interface dual_port_ram_pipe_if #(
    parameter int DATA_RAM_WIDTH = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int BYTE_WIDTH     = 8
);
    localparam int NB = DATA_RAM_WIDTH / BYTE_WIDTH;

    logic [ADDR_WIDTH-1:0]     address_0;
    logic                      chip_enable_0;
    logic                      write_read_0;
    logic [DATA_RAM_WIDTH-1:0] data_0;
    logic [NB-1:0]             byte_enable_0;
    logic [ADDR_WIDTH-1:0]     address_1;
    logic                      chip_enable_1;
    logic                      write_read_1;
    logic [DATA_RAM_WIDTH-1:0] data_1;
    logic                      data_1_valid;
    logic                      init_busy;

    modport master (
        output address_0, chip_enable_0, write_read_0, data_0, byte_enable_0,
        output address_1, chip_enable_1, write_read_1,
        input  data_1, data_1_valid, init_busy
    );

    modport slave (
        input  address_0, chip_enable_0, write_read_0, data_0, byte_enable_0,
        input  address_1, chip_enable_1, write_read_1,
        output data_1, data_1_valid, init_busy
    );
endinterface

// File: rtl/dual_port_ram_pipe.sv
// Simple dual-port RAM (port 0 byte-masked write, port 1 read) with a zeroing sweep after reset.
// Read data READ_LATENCY (1 or 2) cycles after accept; full throughput on both ports.
// No backpressure; requests during the sweep (init_busy=1) are silently dropped.
module dual_port_ram_pipe #(
    parameter int DATA_RAM_WIDTH = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int BYPASS         = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    dual_port_ram_pipe_if.slave bus
);
    localparam int NB        = DATA_RAM_WIDTH / BYTE_WIDTH;
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {INIT, READY} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [ADDR_WIDTH-1:0]     clr_cnt;
    logic [DATA_RAM_WIDTH-1:0] mem [RAM_DEPTH];

    logic                      wr_acc;
    logic                      rd_acc;
    logic [DATA_RAM_WIDTH-1:0] wr_mask;
    logic [DATA_RAM_WIDTH-1:0] rd_word;

    logic                      s1_vld;
    logic [DATA_RAM_WIDTH-1:0] s1_dat;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (clr_cnt == '1) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)              clr_cnt <= '0;
        else if (state == INIT)  clr_cnt <= clr_cnt + 1'b1;
    end

    assign bus.init_busy = (state == INIT);
    assign wr_acc = (state == READY) && bus.chip_enable_0 && bus.write_read_0;
    assign rd_acc = (state == READY) && bus.chip_enable_1 && !bus.write_read_1;

    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < NB; i++)
            wr_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{bus.byte_enable_0[i]}};
    end

    // Sweep and user writes share the single write port; rst_n gates both so a reset edge never writes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == INIT) begin
                mem[clr_cnt] <= '0;
            end else if (wr_acc) begin
                for (int i = 0; i < NB; i++)
                    if (bus.byte_enable_0[i])
                        mem[bus.address_0][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.data_0[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Write-first collision: splice the enabled write lanes over the stored word.
    always_comb begin
        rd_word = mem[bus.address_1];
        if ((BYPASS != 0) && wr_acc && (bus.address_0 == bus.address_1))
            rd_word = (rd_word & ~wr_mask) | (bus.data_0 & wr_mask);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= rd_acc;
            if (rd_acc) s1_dat <= rd_word;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                      s2_vld;
            logic [DATA_RAM_WIDTH-1:0] s2_dat;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s2_vld <= 1'b0;
                    s2_dat <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) s2_dat <= s1_dat;
                end
            end

            assign bus.data_1       = s2_dat;
            assign bus.data_1_valid = s2_vld;
        end else begin : g_lat1
            assign bus.data_1       = s1_dat;
            assign bus.data_1_valid = s1_vld;
        end
    endgenerate
endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// Bench for dual_port_ram_pipe: two instances (latency 1 write-first, latency 2 read-first) share stimulus.
// A byte-lane memory model pushes expected read words with due cycles; monitors pop and compare.
module tb_dual_port_ram_pipe;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int BW = 8;
    localparam int NB = DW / BW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] a0 = '0, a1 = '0;
    logic          ce0 = 1'b0, wr0 = 1'b0, ce1 = 1'b0, wr1 = 1'b0;
    logic [DW-1:0] d0 = '0;
    logic [NB-1:0] be0 = '0;

    dual_port_ram_pipe_if #(.DATA_RAM_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) if_a ();
    dual_port_ram_pipe_if #(.DATA_RAM_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) if_b ();

    assign if_a.address_0 = a0;  assign if_b.address_0 = a0;
    assign if_a.chip_enable_0 = ce0; assign if_b.chip_enable_0 = ce0;
    assign if_a.write_read_0 = wr0;  assign if_b.write_read_0 = wr0;
    assign if_a.data_0 = d0;  assign if_b.data_0 = d0;
    assign if_a.byte_enable_0 = be0; assign if_b.byte_enable_0 = be0;
    assign if_a.address_1 = a1;  assign if_b.address_1 = a1;
    assign if_a.chip_enable_1 = ce1; assign if_b.chip_enable_1 = ce1;
    assign if_a.write_read_1 = wr1;  assign if_b.write_read_1 = wr1;

    dual_port_ram_pipe #(.DATA_RAM_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
                         .READ_LATENCY(1), .BYPASS(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    dual_port_ram_pipe #(.DATA_RAM_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
                         .READ_LATENCY(2), .BYPASS(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    bit mdl_ready = 1'b0;
    logic [DW-1:0] mdl [1<<AW];
    logic [DW-1:0] qa_dat [$];
    int            qa_due [$];
    logic [DW-1:0] qb_dat [$];
    int            qb_due [$];
    logic [DW-1:0] last_a = '0, last_b = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors, sampled just after the active edge.
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            total++;
            if (if_a.data_1_valid === 1'b1) begin
                if (qa_dat.size() == 0) begin
                    bad++; $display("FAIL a_unexpected_valid cyc=%0d data=%h required no pulse", cyc, if_a.data_1);
                end else if (if_a.data_1 !== qa_dat[0] || cyc != qa_due[0]) begin
                    bad++; $display("FAIL a_read cyc=%0d data=%h required data=%h at cyc=%0d", cyc, if_a.data_1, qa_dat[0], qa_due[0]);
                    void'(qa_dat.pop_front()); void'(qa_due.pop_front());
                end else begin
                    void'(qa_dat.pop_front()); void'(qa_due.pop_front());
                end
                last_a = if_a.data_1;
            end else if (if_a.data_1_valid !== 1'b0 || if_a.data_1 !== last_a) begin
                bad++; $display("FAIL a_hold cyc=%0d valid=%b data=%h required valid=0 data=%h", cyc, if_a.data_1_valid, if_a.data_1, last_a);
            end else if (qa_due.size() != 0 && qa_due[0] <= cyc) begin
                bad++; $display("FAIL a_missing cyc=%0d no pulse, required data=%h at cyc=%0d", cyc, qa_dat[0], qa_due[0]);
                void'(qa_dat.pop_front()); void'(qa_due.pop_front());
            end

            total++;
            if (if_b.data_1_valid === 1'b1) begin
                if (qb_dat.size() == 0) begin
                    bad++; $display("FAIL b_unexpected_valid cyc=%0d data=%h required no pulse", cyc, if_b.data_1);
                end else if (if_b.data_1 !== qb_dat[0] || cyc != qb_due[0]) begin
                    bad++; $display("FAIL b_read cyc=%0d data=%h required data=%h at cyc=%0d", cyc, if_b.data_1, qb_dat[0], qb_due[0]);
                    void'(qb_dat.pop_front()); void'(qb_due.pop_front());
                end else begin
                    void'(qb_dat.pop_front()); void'(qb_due.pop_front());
                end
                last_b = if_b.data_1;
            end else if (if_b.data_1_valid !== 1'b0 || if_b.data_1 !== last_b) begin
                bad++; $display("FAIL b_hold cyc=%0d valid=%b data=%h required valid=0 data=%h", cyc, if_b.data_1_valid, if_b.data_1, last_b);
            end else if (qb_due.size() != 0 && qb_due[0] <= cyc) begin
                bad++; $display("FAIL b_missing cyc=%0d no pulse, required data=%h at cyc=%0d", cyc, qb_dat[0], qb_due[0]);
                void'(qb_dat.pop_front()); void'(qb_due.pop_front());
            end
        end
    end

    // One request cycle on both ports; the model decides what each instance must return.
    task automatic op(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [NB-1:0] be, input bit re, input logic [AW-1:0] ra, input bit rw1);
        logic [DW-1:0] old_w, merged;
        @(negedge clk);
        ce0 = 1'b1; wr0 = we; a0 = wa; d0 = wd; be0 = be;
        ce1 = re; wr1 = rw1; a1 = ra;
        if (mdl_ready) begin
            old_w = mdl[ra];
            merged = old_w;
            for (int i = 0; i < NB; i++)
                if (be[i]) merged[i*BW +: BW] = wd[i*BW +: BW];
            if (re && !rw1) begin
                qa_dat.push_back((we && wa == ra) ? merged : old_w);
                qa_due.push_back(cyc + 1);
                qb_dat.push_back(old_w);
                qb_due.push_back(cyc + 2);
            end
            if (we)
                for (int i = 0; i < NB; i++)
                    if (be[i]) mdl[wa][i*BW +: BW] = wd[i*BW +: BW];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic assert_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        ce0 = 1'b0; wr0 = 1'b0; ce1 = 1'b0; wr1 = 1'b0;
        mdl_ready = 1'b0;
        qa_dat.delete(); qa_due.delete(); qb_dat.delete(); qb_due.delete();
        last_a = '0; last_b = '0;
        for (int i = 0; i < n; i++) @(negedge clk);
        total++;
        if (if_a.data_1 !== '0 || if_b.data_1 !== '0 || if_a.data_1_valid !== 1'b0 ||
            if_b.data_1_valid !== 1'b0 || if_a.init_busy !== 1'b1 || if_b.init_busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_state data=%h/%h valid=%b/%b busy=%b/%b required 0/0 0/0 1/1",
                     if_a.data_1, if_b.data_1, if_a.data_1_valid, if_b.data_1_valid, if_a.init_busy, if_b.init_busy);
        end
        rst_n = 1'b1;
    endtask

    // Count busy cycles from release while hammering both ports; they must be ignored.
    task automatic wait_init();
        int cnt_a, cnt_b, n;
        cnt_a = 0; cnt_b = 0; n = 0;
        ce0 = 1'b1; wr0 = 1'b1; a0 = 4'd9; d0 = 32'hFFFF_FFFF; be0 = '1;
        ce1 = 1'b1; wr1 = 1'b0; a1 = 4'd9;
        while ((if_a.init_busy || if_b.init_busy) && n < 40) begin
            n++;
            if (if_a.init_busy) cnt_a++;
            if (if_b.init_busy) cnt_b++;
            @(posedge clk); #1;
        end
        ce0 = 1'b0; wr0 = 1'b0; ce1 = 1'b0;
        total++;
        if (cnt_a != (1 << AW) || cnt_b != (1 << AW)) begin
            bad++; $display("FAIL init_len busy_cycles=%0d/%0d required %0d", cnt_a, cnt_b, 1 << AW);
        end
        for (int i = 0; i < (1 << AW); i++) mdl[i] = '0;
        mdl_ready = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa_dat.size() != 0 || qb_dat.size() != 0) && n < 10) begin
            @(posedge clk); #3; n++;
        end
        total++;
        if (qa_dat.size() != 0 || qb_dat.size() != 0) begin
            bad++; $display("FAIL drain pending=%0d/%0d required 0/0", qa_dat.size(), qb_dat.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (if_a.data_1 !== '0 || if_b.data_1 !== '0 || if_a.data_1_valid !== 1'b0 ||
            if_b.data_1_valid !== 1'b0 || if_a.init_busy !== 1'b1 || if_b.init_busy !== 1'b1) begin
            bad++; $display("FAIL power_on_reset data=%h/%h busy=%b/%b required 0/0 1/1",
                            if_a.data_1, if_b.data_1, if_a.init_busy, if_b.init_busy);
        end
        mon_en = 1'b1;
        rst_n = 1'b1;
        wait_init();
    endtask

    task automatic test_init_zero();
        for (int i = 0; i < (1 << AW); i++) op(1'b0, '0, '0, '0, 1'b1, AW'(i), 1'b0);
        idle(3);
    endtask

    task automatic test_byte_enable();
        op(1'b1, 4'd3, 32'h1122_3344, 4'hF, 1'b0, '0, 1'b0);
        op(1'b1, 4'd3, 32'hA5A5_A5A5, 4'b0101, 1'b0, '0, 1'b0);
        op(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
        op(1'b1, 4'd3, 32'h0BAD_F00D, 4'h0, 1'b0, '0, 1'b0);
        op(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
        op(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b1);
        idle(3);
    endtask

    task automatic test_collision();
        op(1'b1, 4'd7, 32'hDEAD_BEEF, 4'hF, 1'b1, 4'd7, 1'b0);
        op(1'b1, 4'd7, 32'h1234_5678, 4'b1001, 1'b1, 4'd7, 1'b0);
        op(1'b0, '0, '0, '0, 1'b1, 4'd7, 1'b0);
        idle(3);
    endtask

    task automatic test_back_to_back();
        op(1'b1, 4'd0, 32'h10, 4'hF, 1'b0, '0, 1'b0);
        op(1'b1, 4'd1, 32'h20, 4'hF, 1'b0, '0, 1'b0);
        op(1'b1, 4'd2, 32'h30, 4'hF, 1'b0, '0, 1'b0);
        op(1'b0, '0, '0, '0, 1'b1, 4'd0, 1'b0);
        op(1'b0, '0, '0, '0, 1'b1, 4'd1, 1'b0);
        op(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
        op(1'b1, 4'd4, 32'hCAFE_0004, 4'hF, 1'b1, 4'd2, 1'b0);
        op(1'b1, 4'd2, 32'h9999_9999, 4'hF, 1'b1, 4'd4, 1'b0);
        op(1'b1, 4'd15, 32'hF00D_000F, 4'hF, 1'b1, 4'd2, 1'b0);
        op(1'b0, '0, '0, '0, 1'b1, 4'd15, 1'b0);
        op(1'b0, '0, '0, '0, 1'b1, 4'd0, 1'b0);
        idle(3);
    endtask

    task automatic test_in_flight();
        op(1'b1, 4'd5, 32'h5555_0005, 4'hF, 1'b0, '0, 1'b0);
        op(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
        op(1'b1, 4'd5, 32'h6666_0006, 4'hF, 1'b1, 4'd5, 1'b0);
        op(1'b1, 4'd5, 32'h7777_0007, 4'hF, 1'b0, '0, 1'b0);
        op(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
        idle(3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            op(1'($urandom), AW'($urandom), $urandom, NB'($urandom), 1'($urandom),
               AW'($urandom), ($urandom_range(0, 7) == 0));
        idle(3);
    endtask

    task automatic test_reset_mid();
        op(1'b1, 4'd9, 32'h9090_9090, 4'hF, 1'b0, '0, 1'b0);
        op(1'b0, '0, '0, '0, 1'b1, 4'd9, 1'b0);
        assert_reset(1);
        for (int i = 0; i < 8; i++) op(1'b1, AW'(i), 32'hABCD_0000, 4'hF, 1'b1, AW'(i), 1'b0);
        total++;
        if (if_a.init_busy !== 1'b1) begin
            bad++; $display("FAIL sweep_busy busy=%b required 1", if_a.init_busy);
        end
        assert_reset(1);
        wait_init();
        for (int i = 0; i < (1 << AW); i++) op(1'b0, '0, '0, '0, 1'b1, AW'(i), 1'b0);
        idle(3);
    endtask

    initial begin
        test_reset();
        test_init_zero();
        test_byte_enable();
        test_collision();
        test_back_to_back();
        test_in_flight();
        test_random();
        test_reset_mid();
        test_random();
        drain();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dual_port_ram_pipe.md
DUAL_PORT_RAM_PIPE -- requirements
Module: dual_port_ram_pipe

Interface
REQ-001 SHALL provide parameter DATA_RAM_WIDTH, default 32, word width in bits; SHALL be an integer multiple of BYTE_WIDTH.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 8, address width; RAM_DEPTH = 2^ADDR_WIDTH words.
REQ-003 SHALL provide parameter BYTE_WIDTH, default 8, bits per byte lane; NB = DATA_RAM_WIDTH/BYTE_WIDTH lanes.
REQ-004 SHALL provide parameter READ_LATENCY, default 1, legal values 1 or 2, cycles from read accept to data_1 update.
REQ-005 SHALL provide parameter BYPASS, default 1; 1 = write-first on same-address collision, 0 = read-first.
REQ-006 SHALL have one clock and a synchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-007 address_0  input  ADDR_WIDTH  write-port address.
REQ-008 chip_enable_0  input  1  write-port enable.
REQ-009 write_read_0  input  1  1 = write; 0 = no operation on port 0.
REQ-010 data_0  input  DATA_RAM_WIDTH  write data.
REQ-011 byte_enable_0  input  NB  per-lane write mask; bit i covers data_0[i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-012 address_1  input  ADDR_WIDTH  read-port address.
REQ-013 chip_enable_1  input  1  read-port enable.
REQ-014 write_read_1  input  1  0 = read; 1 = ignored (port 1 is read-only).
REQ-015 data_1  output  DATA_RAM_WIDTH  read data, registered.
REQ-016 data_1_valid  output  1  one-cycle pulse coincident with each new data_1 value.
REQ-017 init_busy  output  1  high while the memory clear sweep is running.

Function
REQ-018 SHALL implement FSM states INIT and READY; rst_n low forces INIT with sweep counter = 0.
REQ-019 In INIT: SHALL write 0 to memory[counter] each cycle, increment counter; after writing RAM_DEPTH-1, SHALL enter READY the next cycle (INIT lasts exactly RAM_DEPTH cycles after rst_n rises).
REQ-020 init_busy SHALL be 1 exactly while state = INIT.
REQ-021 In INIT, port 0 writes and port 1 reads SHALL be ignored (no memory change, no data_1_valid).
REQ-022 In READY, write accepted when chip_enable_0 & write_read_0; only lanes with byte_enable_0[i]=1 SHALL update; byte_enable_0 = 0 leaves memory unchanged.
REQ-023 In READY, read accepted when chip_enable_1 & !write_read_1; data_1 and data_1_valid SHALL update READ_LATENCY cycles after the accept edge.
REQ-024 Back-to-back reads SHALL be accepted every cycle (full throughput, both latencies).
REQ-025 data_1 SHALL hold its last value when no read completes; data_1_valid SHALL be 0 in those cycles.
REQ-026 Same-address write and read in the same cycle: BYPASS=1 returns the merged word (enabled lanes from data_0, others from memory); BYPASS=0 returns pre-write contents.
REQ-027 Write and read to different addresses in the same cycle SHALL both complete without interaction.
REQ-028 Address wrap: addresses SHALL be used modulo RAM_DEPTH; no out-of-range condition exists.
REQ-029 For READ_LATENCY=2, stage-2 data SHALL be the captured stage-1 value; a write after the accept cycle SHALL NOT alter an in-flight read.

Reset
REQ-030 On rst_n low at a clk edge: data_1 = 0, data_1_valid = 0, read pipeline valid bits = 0, state = INIT, counter = 0, init_busy = 1 from that edge.
REQ-031 Reset asserted mid-sweep or mid-read SHALL restart the sweep from address 0 and discard in-flight reads.
REQ-032 Memory SHALL NOT be cleared in a single cycle; clearing is done only by the INIT sweep.

Verification
REQ-033 ADDR_WIDTH=4: release rst_n -> init_busy high for exactly 16 cycles; read of all 16 addresses afterwards returns 0.
REQ-034 Write 0xA5A5A5A5 to addr 3 with byte_enable_0=4'b0101, memory previously 0x11223344 -> read addr 3 returns 0x11A533A5.
REQ-035 BYPASS=1, same cycle write 0xDEADBEEF (all lanes) and read addr 7 holding 0x0 -> data_1 = 0xDEADBEEF; BYPASS=0 -> data_1 = 0x0.
REQ-036 READ_LATENCY=2, reads to addrs 0,1,2 on consecutive cycles holding 0x10,0x20,0x30 -> data_1_valid high cycles 2,3,4 after first accept with 0x10,0x20,0x30.
REQ-037 Assert rst_n low for one cycle during sweep at counter 9 and with one read in flight -> no data_1_valid pulse, data_1 = 0, sweep restarts at 0, init_busy high 2^ADDR_WIDTH cycles after release.
REQ-038 Write and read attempted while init_busy=1 -> no data_1_valid; memory reads 0 after READY.
